// File: rtl/gpu_io_pkg.sv
// Shared definitions for the per-core thread register window and the
// command sequencer that consumes it.
//   - byte offsets of the status/control words and the first command slot
//   - bit positions of status.busy and control.start
//   - END opcode value and the bit range of the opcode field in word0
//   - sequencer state encoding
package gpu_io_pkg;

    localparam int STATUS_OFFSET     = 4;
    localparam int CONTROL_OFFSET    = 8;
    localparam int CMD_BASE_OFFSET   = 12;

    localparam int STATUS_BUSY_BIT   = 0;
    localparam int CONTROL_START_BIT = 0;

    localparam logic [7:0] OPCODE_END = 8'h00;
    localparam int OPCODE_LSB        = 0;
    localparam int OPCODE_MSB        = 7;

    typedef enum logic [2:0] {
        POLL,
        SET_BUSY,
        FETCH,
        ISSUE,
        DRAIN,
        CLR_CTRL,
        CLR_STAT
    } seq_state_t;

endpackage

// File: rtl/thread_command_sequencer.sv
// Per-core command sequencer. Polls the control word of the thread register
// window, marks the thread busy, fetches each 96-bit command and hands it
// to the execution unit over valid/ready, then waits for the core to go idle
// and clears control and status.
//
// Ports:
//   gpu_clk, gpu_reset      clock, synchronous active-high reset
//   reg_address             byte address into the window (port B)
//   reg_rd_data             read data, valid the cycle after reg_address
//   reg_wr_data, reg_wr_en  write data and byte enables
//   cmd_valid/ready/data    command handshake to the execution unit
//   cmd_index               slot number of the presented command
//   core_idle               core has no command in flight
//   seq_busy                sequencer is outside POLL
//
// state    | meaning
// ---------+--------------------------------------------------------
// POLL     | read control every cycle, start a run on start bit
// SET_BUSY | write status = busy
// FETCH    | read the three words of command k (4 cycles)
// ISSUE    | present command k until cmd_ready
// DRAIN    | wait for the core to finish in-flight work
// CLR_CTRL | write control = 0
// CLR_STAT | write status = 0
module thread_command_sequencer
    import gpu_io_pkg::*;
#(
    parameter int COMMAND_COUNT     = 4,
    parameter int BYTES_PER_WORD    = 4,
    parameter int BYTES_PER_COMMAND = 12,
    parameter int ADDR_W            = $clog2(12 + BYTES_PER_COMMAND * COMMAND_COUNT),
    localparam int IDX_W            = (COMMAND_COUNT > 1) ? $clog2(COMMAND_COUNT) : 1
) (
    input  logic              gpu_clk,
    input  logic              gpu_reset,
    output logic [ADDR_W-1:0] reg_address,
    input  logic [31:0]       reg_rd_data,
    output logic [31:0]       reg_wr_data,
    output logic [3:0]        reg_wr_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [95:0]       cmd_data,
    output logic [IDX_W-1:0]  cmd_index,
    input  logic              core_idle,
    output logic              seq_busy
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(COMMAND_COUNT - 1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(CONTROL_OFFSET);
    localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(STATUS_OFFSET);

    seq_state_t        state_q;
    logic [IDX_W-1:0]  k_q;
    logic [1:0]        fcnt_q;
    logic [31:0]       w0_q;
    logic [31:0]       w1_q;
    logic              poll_armed_q;
    logic [ADDR_W-1:0] reg_address_q;
    logic [31:0]       reg_wr_data_q;
    logic [3:0]        reg_wr_en_q;
    logic              cmd_valid_q;
    logic [95:0]       cmd_data_q;
    logic [IDX_W-1:0]  cmd_index_q;
    logic              seq_busy_q;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0] k,
                                                    input logic [1:0] w);
        int a;
        a = CMD_BASE_OFFSET + BYTES_PER_COMMAND * int'(k) + BYTES_PER_WORD * int'(w);
        return ADDR_W'(a);
    endfunction

    // Outputs are registered: every transition loads the bus values that
    // belong to the state being entered, so they line up with state_q.
    always_ff @(posedge gpu_clk) begin
        if (gpu_reset) begin
            state_q       <= POLL;
            k_q           <= '0;
            fcnt_q        <= '0;
            w0_q          <= '0;
            w1_q          <= '0;
            poll_armed_q  <= 1'b0;
            reg_address_q <= ADDR_CTRL;
            reg_wr_data_q <= '0;
            reg_wr_en_q   <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_data_q    <= '0;
            cmd_index_q   <= '0;
            seq_busy_q    <= 1'b0;
        end else begin
            case (state_q)
                POLL: begin
                    reg_address_q <= ADDR_CTRL;
                    // The first sample after entry reflects whatever address
                    // was driven before POLL, so it is skipped.
                    poll_armed_q  <= 1'b1;
                    if (poll_armed_q && reg_rd_data[CONTROL_START_BIT]) begin
                        state_q       <= SET_BUSY;
                        reg_address_q <= ADDR_STAT;
                        reg_wr_en_q   <= 4'hF;
                        reg_wr_data_q <= 32'h1 << STATUS_BUSY_BIT;
                        seq_busy_q    <= 1'b1;
                    end
                end
                SET_BUSY: begin
                    state_q       <= FETCH;
                    k_q           <= '0;
                    fcnt_q        <= '0;
                    reg_address_q <= slot_addr('0, 2'd0);
                    reg_wr_en_q   <= '0;
                    reg_wr_data_q <= '0;
                end
                FETCH: begin
                    fcnt_q <= fcnt_q + 2'd1;
                    // Park on the control word after the last read so no
                    // command slot is touched outside FETCH.
                    if (fcnt_q < 2'd2) begin
                        reg_address_q <= slot_addr(k_q, fcnt_q + 2'd1);
                    end else begin
                        reg_address_q <= ADDR_CTRL;
                    end
                    case (fcnt_q)
                        2'd1: w0_q <= reg_rd_data;
                        2'd2: w1_q <= reg_rd_data;
                        2'd3: begin
                            if (w0_q[OPCODE_MSB:OPCODE_LSB] == OPCODE_END) begin
                                state_q <= DRAIN;
                            end else begin
                                state_q     <= ISSUE;
                                cmd_valid_q <= 1'b1;
                                cmd_data_q  <= {reg_rd_data, w1_q, w0_q};
                                cmd_index_q <= k_q;
                            end
                        end
                        default: ;
                    endcase
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        if (k_q == LAST_IDX) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q       <= FETCH;
                            k_q           <= k_q + 1'b1;
                            fcnt_q        <= '0;
                            reg_address_q <= slot_addr(k_q + 1'b1, 2'd0);
                        end
                    end
                end
                DRAIN: begin
                    if (core_idle) begin
                        state_q       <= CLR_CTRL;
                        reg_address_q <= ADDR_CTRL;
                        reg_wr_en_q   <= 4'hF;
                        reg_wr_data_q <= '0;
                    end
                end
                CLR_CTRL: begin
                    state_q       <= CLR_STAT;
                    reg_address_q <= ADDR_STAT;
                    reg_wr_en_q   <= 4'hF;
                    reg_wr_data_q <= '0;
                end
                CLR_STAT: begin
                    state_q       <= POLL;
                    reg_address_q <= ADDR_CTRL;
                    reg_wr_en_q   <= '0;
                    reg_wr_data_q <= '0;
                    seq_busy_q    <= 1'b0;
                    poll_armed_q  <= 1'b0;
                end
                default: begin
                    state_q       <= POLL;
                    reg_address_q <= ADDR_CTRL;
                    reg_wr_en_q   <= '0;
                    cmd_valid_q   <= 1'b0;
                    seq_busy_q    <= 1'b0;
                    poll_armed_q  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_address = reg_address_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_data    = cmd_data_q;
    assign cmd_index   = cmd_index_q;
    assign seq_busy    = seq_busy_q;

endmodule

// File: tb/tb_thread_command_sequencer.sv
// Directed bench for thread_command_sequencer: a 16-word window model with
// one cycle of read latency, a negedge monitor that logs writes and
// transfers, and one task per scenario.
module tb_thread_command_sequencer;

    localparam int AW = 6;

    logic          gpu_clk = 1'b0;
    logic          gpu_reset;
    logic [AW-1:0] reg_address;
    logic [31:0]   reg_rd_data;
    logic [31:0]   reg_wr_data;
    logic [3:0]    reg_wr_en;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [95:0]   cmd_data;
    logic [1:0]    cmd_index;
    logic          core_idle;
    logic          seq_busy;

    thread_command_sequencer dut (
        .gpu_clk     (gpu_clk),
        .gpu_reset   (gpu_reset),
        .reg_address (reg_address),
        .reg_rd_data (reg_rd_data),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_index   (cmd_index),
        .core_idle   (core_idle),
        .seq_busy    (seq_busy)
    );

    always #5 gpu_clk = ~gpu_clk;

    int cyc = 0;
    always @(posedge gpu_clk) cyc <= cyc + 1;

    // window model; host pokes take priority over DUT writes
    logic [31:0] mem [0:15];
    logic        host_we = 1'b0;
    logic [3:0]  host_idx = '0;
    logic [31:0] host_val = '0;

    always @(posedge gpu_clk) begin
        reg_rd_data <= mem[reg_address[AW-1:2]];
        if (host_we) begin
            mem[host_idx] <= host_val;
        end else begin
            for (int b = 0; b < 4; b++)
                if (reg_wr_en[b]) mem[reg_address[AW-1:2]][8*b +: 8] <= reg_wr_data[8*b +: 8];
        end
    end

    // monitor logs
    logic [AW-1:0] wlog_addr [16];
    logic [31:0]   wlog_data [16];
    int            wlog_cyc  [16];
    int            wcnt;
    logic [1:0]    xlog_idx  [16];
    logic [95:0]   xlog_data [16];
    int            xcnt;
    int            slot_reads;
    int            v2_cycles;
    int            v2_changes;
    logic [95:0]   v2_first;
    int            rise_cyc;
    int            wcnt_at_rise;

    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge gpu_clk) begin
        if (!gpu_reset) begin
            if (reg_wr_en != 4'h0) begin
                if (wcnt < 16) begin
                    wlog_addr[wcnt] = reg_address;
                    wlog_data[wcnt] = reg_wr_data;
                    wlog_cyc[wcnt]  = cyc;
                end
                wcnt++;
            end
            if (cmd_valid && cmd_ready) begin
                if (xcnt < 16) begin
                    xlog_idx[xcnt]  = cmd_index;
                    xlog_data[xcnt] = cmd_data;
                end
                xcnt++;
            end
            if (cmd_valid && cmd_index == 2'd2) begin
                if (v2_cycles == 0) v2_first = cmd_data;
                else if (cmd_data != v2_first) v2_changes++;
                v2_cycles++;
            end
            if (reg_address >= AW'(12)) slot_reads++;
        end
    end

    function automatic logic [95:0] exp_cmd(input int k);
        return {32'h2222_0000 + 32'(k), 32'h1111_0000 + 32'(k), 32'h0000_0101 + 32'(k)};
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        host_idx = 4'(idx);
        host_val = val;
        host_we  = 1'b1;
        @(posedge gpu_clk);
        #1;
        host_we  = 1'b0;
    endtask

    task automatic clear_logs();
        wcnt = 0; xcnt = 0; slot_reads = 0;
        v2_cycles = 0; v2_changes = 0; v2_first = '0;
        rise_cyc = -1; wcnt_at_rise = -1;
    endtask

    task automatic load_list(input bit early_end);
        for (int k = 0; k < 4; k++) begin
            logic [95:0] c;
            c = exp_cmd(k);
            if (early_end && k == 1) c[31:0] = 32'h0000_0100;
            poke(3 + 3*k + 0, c[31:0]);
            poke(3 + 3*k + 1, c[63:32]);
            poke(3 + 3*k + 2, c[95:64]);
        end
        clear_logs();
        poke(2, 32'h1);
    endtask

    // Runs until seq_busy has risen and fallen again, driving cmd_ready and
    // core_idle one cycle at a time.
    task automatic run(input int stall_idx, input int stall_len, input int drain_hold,
                       output bit ok);
        int stall_cnt;
        int after;
        bit seen;
        stall_cnt = 0; after = -1; seen = 0; ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge gpu_clk);
            #1;
            if (cmd_valid && int'(cmd_index) == stall_idx && stall_cnt < stall_len) begin
                cmd_ready = 1'b0;
                stall_cnt++;
            end else begin
                cmd_ready = 1'b1;
            end
            if (drain_hold > 0) begin
                if (after < 0 && xcnt == 4) after = 0;
                else if (after >= 0 && after < drain_hold) after++;
                core_idle = (after == drain_hold);
                if (after == drain_hold && rise_cyc < 0) begin
                    rise_cyc     = cyc;
                    wcnt_at_rise = wcnt;
                end
            end
            if (seq_busy) seen = 1;
            else if (seen) begin
                ok = 1;
                break;
            end
        end
        cmd_ready = 1'b1;
        core_idle = 1'b1;
    endtask

    task automatic check_done(input string name, input bit ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout: run did not complete within budget", name);
        end
    endtask

    task automatic check_cleanup(input string name, input int first);
        n_cmp++;
        if ({wlog_addr[first], wlog_data[first]} !== {AW'(8), 32'h0}) begin
            n_bad++;
            $display("FAIL %s_ctrl_clear: got addr %0d data %0h, expected addr 8 data 0",
                     name, wlog_addr[first], wlog_data[first]);
        end
        n_cmp++;
        if ({wlog_addr[first+1], wlog_data[first+1]} !== {AW'(4), 32'h0}) begin
            n_bad++;
            $display("FAIL %s_stat_clear: got addr %0d data %0h, expected addr 4 data 0",
                     name, wlog_addr[first+1], wlog_data[first+1]);
        end
    endtask

    task automatic test_reset();
        gpu_reset = 1'b1;
        cmd_ready = 1'b1;
        core_idle = 1'b1;
        for (int i = 0; i < 16; i++) poke(i, 32'h0);
        @(negedge gpu_clk);
        n_cmp += 7;
        if (reg_address !== AW'(8)) begin n_bad++; $display("FAIL rst_addr: got %0d expected 8", reg_address); end
        if (reg_wr_en !== 4'h0) begin n_bad++; $display("FAIL rst_wr_en: got %0h expected 0", reg_wr_en); end
        if (reg_wr_data !== 32'h0) begin n_bad++; $display("FAIL rst_wr_data: got %0h expected 0", reg_wr_data); end
        if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid: got %0b expected 0", cmd_valid); end
        if (cmd_data !== 96'h0) begin n_bad++; $display("FAIL rst_cmd_data: got %0h expected 0", cmd_data); end
        if (cmd_index !== 2'd0) begin n_bad++; $display("FAIL rst_cmd_index: got %0d expected 0", cmd_index); end
        if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL rst_seq_busy: got %0b expected 0", seq_busy); end
        @(posedge gpu_clk);
        #1;
        gpu_reset = 1'b0;
    endtask

    task automatic test_idle_poll();
        int bad_addr, bad_wr, bad_valid;
        bad_addr = 0; bad_wr = 0; bad_valid = 0;
        repeat (50) begin
            @(negedge gpu_clk);
            if (reg_address !== AW'(8)) bad_addr++;
            if (reg_wr_en !== 4'h0) bad_wr++;
            if (cmd_valid !== 1'b0) bad_valid++;
        end
        n_cmp += 3;
        if (bad_addr != 0) begin n_bad++; $display("FAIL idle_addr: %0d cycles off address 8, expected 0", bad_addr); end
        if (bad_wr != 0) begin n_bad++; $display("FAIL idle_wr_en: %0d write cycles, expected 0", bad_wr); end
        if (bad_valid != 0) begin n_bad++; $display("FAIL idle_cmd_valid: %0d valid cycles, expected 0", bad_valid); end
    endtask

    task automatic test_full_list();
        bit ok;
        int snap;
        load_list(1'b0);
        run(-1, 0, 0, ok);
        check_done("full", ok);
        n_cmp++;
        if (wcnt !== 3) begin n_bad++; $display("FAIL full_write_count: got %0d expected 3", wcnt); end
        n_cmp++;
        if ({wlog_addr[0], wlog_data[0]} !== {AW'(4), 32'h1}) begin
            n_bad++;
            $display("FAIL full_set_busy: got addr %0d data %0h expected addr 4 data 1", wlog_addr[0], wlog_data[0]);
        end
        check_cleanup("full", 1);
        n_cmp++;
        if (xcnt !== 4) begin n_bad++; $display("FAIL full_xfer_count: got %0d expected 4", xcnt); end
        for (int k = 0; k < 4; k++) begin
            n_cmp += 2;
            if (xlog_idx[k] !== 2'(k)) begin n_bad++; $display("FAIL full_index%0d: got %0d expected %0d", k, xlog_idx[k], k); end
            if (xlog_data[k] !== exp_cmd(k)) begin
                n_bad++;
                $display("FAIL full_data%0d: got %h expected %h", k, xlog_data[k], exp_cmd(k));
            end
        end
        snap = slot_reads;
        repeat (20) @(posedge gpu_clk);
        #1;
        n_cmp += 3;
        if (slot_reads !== snap) begin n_bad++; $display("FAIL full_post_reads: got %0d slot reads after run, expected 0", slot_reads - snap); end
        if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL full_seq_busy: got %0b expected 0", seq_busy); end
        if (mem[2] !== 32'h0) begin n_bad++; $display("FAIL full_control_word: got %0h expected 0", mem[2]); end
    endtask

    task automatic test_early_end();
        bit ok;
        load_list(1'b1);
        run(-1, 0, 0, ok);
        check_done("early", ok);
        n_cmp += 3;
        if (xcnt !== 1) begin n_bad++; $display("FAIL early_xfer_count: got %0d expected 1", xcnt); end
        if (xlog_idx[0] !== 2'd0) begin n_bad++; $display("FAIL early_index: got %0d expected 0", xlog_idx[0]); end
        if (wcnt !== 3) begin n_bad++; $display("FAIL early_write_count: got %0d expected 3", wcnt); end
        check_cleanup("early", 1);
    endtask

    task automatic test_backpressure();
        bit ok;
        int n2;
        load_list(1'b0);
        run(2, 5, 0, ok);
        check_done("bp", ok);
        n2 = 0;
        for (int i = 0; i < 4 && i < xcnt; i++) if (xlog_idx[i] == 2'd2) n2++;
        n_cmp += 5;
        if (xcnt !== 4) begin n_bad++; $display("FAIL bp_xfer_count: got %0d expected 4", xcnt); end
        if (v2_cycles !== 6) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d expected 6", v2_cycles); end
        if (v2_changes !== 0) begin n_bad++; $display("FAIL bp_data_stable: got %0d changes expected 0", v2_changes); end
        if (n2 !== 1) begin n_bad++; $display("FAIL bp_single_xfer: got %0d transfers of index 2 expected 1", n2); end
        if (xlog_data[2] !== exp_cmd(2)) begin n_bad++; $display("FAIL bp_data: got %h expected %h", xlog_data[2], exp_cmd(2)); end
    endtask

    task automatic test_drain();
        bit ok;
        load_list(1'b0);
        run(-1, 0, 10, ok);
        check_done("drain", ok);
        n_cmp += 4;
        if (rise_cyc < 0) begin n_bad++; $display("FAIL drain_rise: core_idle never released, expected release"); end
        if (wcnt_at_rise !== 1) begin n_bad++; $display("FAIL drain_early_write: got %0d writes before idle expected 1", wcnt_at_rise); end
        if (wlog_cyc[1] !== rise_cyc + 1) begin
            n_bad++;
            $display("FAIL drain_ctrl_cycle: got cycle %0d expected %0d", wlog_cyc[1], rise_cyc + 1);
        end
        if (wlog_addr[1] !== AW'(8)) begin n_bad++; $display("FAIL drain_ctrl_addr: got %0d expected 8", wlog_addr[1]); end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit ok;
        load_list(1'b0);
        found = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge gpu_clk);
            #1;
            if (cmd_valid && cmd_index == 2'd1) begin
                cmd_ready = 1'b0;
                gpu_reset = 1'b1;
                found = 1;
                break;
            end
            cmd_ready = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL rmid_reach_issue: index 1 never presented, expected presentation"); end
        @(negedge gpu_clk);
        @(negedge gpu_clk);
        n_cmp += 3;
        if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_cmd_valid: got %0b expected 0", cmd_valid); end
        if (seq_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_seq_busy: got %0b expected 0", seq_busy); end
        if (reg_wr_en !== 4'h0) begin n_bad++; $display("FAIL rmid_wr_en: got %0h expected 0", reg_wr_en); end
        clear_logs();
        @(posedge gpu_clk);
        #1;
        gpu_reset = 1'b0;
        cmd_ready = 1'b1;
        run(-1, 0, 0, ok);
        check_done("rmid", ok);
        n_cmp += 3;
        if (xcnt !== 4) begin n_bad++; $display("FAIL rmid_xfer_count: got %0d expected 4", xcnt); end
        if (xlog_idx[0] !== 2'd0) begin n_bad++; $display("FAIL rmid_restart_index: got %0d expected 0", xlog_idx[0]); end
        if (xlog_data[0] !== exp_cmd(0)) begin n_bad++; $display("FAIL rmid_restart_data: got %h expected %h", xlog_data[0], exp_cmd(0)); end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_idle_poll();
        test_full_list();
        test_early_end();
        test_backpressure();
        test_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
